isqrt_sum_fsm_distributor: RTL and testbench

//  Computes res = sum over i of isqrt(arg[i]) for N_ARGS 32-bit arguments.

---
 rtl/isqrt_sum_fsm_distributor.sv | 125 ++++++++++++
 tb/tb_isqrt_sum_fsm_distributor.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_sum_fsm_distributor.sv
// rtl/isqrt_sum_fsm_distributor.sv - sum of integer square roots over N_ARGS args via N_ISQRT pipelined units
// Batch 0 is issued straight from arg_i in the accept cycle; later batches come from the captured copy.
module isqrt_sum_fsm_distributor #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arg_vld_i,
  output logic                  arg_rdy_o,
  input  logic [N_ARGS*32-1:0]  arg_i,
  output logic                  res_vld_o,
  output logic [31:0]           res_o,
  output logic [N_ISQRT-1:0]    isqrt_x_vld_o,
  output logic [N_ISQRT*32-1:0] isqrt_x_o,
  input  logic [N_ISQRT-1:0]    isqrt_y_vld_i,
  input  logic [N_ISQRT*16-1:0] isqrt_y_i
);

  localparam int NB   = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW   = 16 + $clog2(N_ARGS);
  localparam int PADW = NB * N_ISQRT * 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [N_ARGS*32-1:0] arg_q, arg_d;
  logic [BW-1:0]       iss_q, iss_d, ret_q, ret_d, issue_b;
  logic [AW-1:0]       acc_q, acc_d, res_q, res_d, batch_sum;
  logic                res_vld_q, res_vld_d;
  logic                rdy, issue;
  logic [PADW-1:0]     src_pad;
  logic                unused_y_vld;

  // Only lane 0 marks a batch return; the other valids are redundant.
  assign unused_y_vld = ^isqrt_y_vld_i;

  always_comb begin
    batch_sum = '0;
    for (int j = 0; j < N_ISQRT; j++) begin
      if (int'(ret_q) * N_ISQRT + j < N_ARGS) begin
        batch_sum = batch_sum + AW'(isqrt_y_i[j*16 +: 16]);
      end
    end
  end

  assign src_pad = PADW'((state_q == IDLE) ? arg_i : arg_q);

  always_comb begin
    state_d   = state_q;
    arg_d     = arg_q;
    iss_d     = iss_q;
    ret_d     = ret_q;
    acc_d     = acc_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    rdy       = 1'b0;
    issue     = 1'b0;
    issue_b   = '0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (arg_vld_i) begin
          issue   = 1'b1;
          arg_d   = arg_i;
          acc_d   = '0;
          iss_d   = BW'(1);
          ret_d   = '0;
          state_d = (NB > 1) ? ISSUE : WAIT;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        issue_b = iss_q;
        iss_d   = iss_q + BW'(1);
        if (int'(iss_q) == NB - 1) state_d = WAIT;
      end
      default: ;
    endcase
    if (state_q != IDLE && isqrt_y_vld_i[0]) begin
      ret_d = ret_q + BW'(1);
      acc_d = acc_q + batch_sum;
      if (int'(ret_q) == NB - 1) begin
        res_d     = acc_q + batch_sum;
        res_vld_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  // Combinational outputs are gated by rst_n so they clear without a clock.
  always_comb begin
    arg_rdy_o = rst_n & rdy;
    for (int j = 0; j < N_ISQRT; j++) begin
      isqrt_x_vld_o[j] = rst_n && issue && (int'(issue_b) * N_ISQRT + j < N_ARGS);
      isqrt_x_o[j*32 +: 32] = isqrt_x_vld_o[j] ?
          src_pad[(int'(issue_b) * N_ISQRT + j) * 32 +: 32] : 32'd0;
    end
  end

  assign res_o     = 32'(res_q);
  assign res_vld_o = res_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      arg_q     <= '0;
      iss_q     <= '0;
      ret_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arg_q     <= arg_d;
      iss_q     <= iss_d;
      ret_q     <= ret_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

endmodule

// File: tb/tb_isqrt_sum_fsm_distributor.sv
// tb/tb_isqrt_sum_fsm_distributor.sv - randomized bench for isqrt_sum_fsm_distributor
// Six configurations share clock/reset; each has its own fixed-latency isqrt model.
module tb_isqrt_sum_fsm_distributor;

  localparam int NCFG = 6;
  localparam int MAXN = 9;
  localparam int MAXK = 5;

  function automatic int cfg_n(int c);
    case (c)
      0: return 3;
      1: return 4;
      2: return 3;
      3: return 5;
      4: return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int cfg_k(int c);
    case (c)
      0: return 2;
      1: return 2;
      2: return 4;
      3: return 1;
      4: return 3;
      default: return 5;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  int   lat = 4;
  always #5 clk = ~clk;

  logic [MAXN*32-1:0]  arg_all;
  logic [NCFG-1:0]     arg_vld;
  logic [NCFG-1:0]     arg_rdy;
  logic [NCFG-1:0]     res_vld;
  logic [31:0]         res    [NCFG];
  logic [MAXK-1:0]     xv_all [NCFG];
  logic [MAXK*32-1:0]  x_all  [NCFG];
  int                  pulses [NCFG];
  int                  ops    [NCFG];
  logic [31:0]         a      [MAXN];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] ref_isqrt(logic [31:0] x);
    longint lo = 0;
    longint hi = 65535;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  task automatic check(string tag, logic [MAXK*32-1:0] got, logic [MAXK*32-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int N = cfg_n(g);
    localparam int K = cfg_k(g);
    logic [K-1:0]    xv, yv;
    logic [K*32-1:0] xb;
    logic [K*16-1:0] yb;
    logic [31:0]     r;
    logic            rv, rdy;
    logic [K-1:0]    pv [8];
    logic [K*32-1:0] px [8];
    int              cnt = 0;

    isqrt_sum_fsm_distributor #(.N_ARGS(N), .N_ISQRT(K)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arg_vld_i    (arg_vld[g]),
      .arg_rdy_o    (rdy),
      .arg_i        (arg_all[N*32-1:0]),
      .res_vld_o    (rv),
      .res_o        (r),
      .isqrt_x_vld_o(xv),
      .isqrt_x_o    (xb),
      .isqrt_y_vld_i(yv),
      .isqrt_y_i    (yb)
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) begin
          pv[i] <= '0;
          px[i] <= '0;
        end
      end else begin
        pv[0] <= xv;
        px[0] <= xb;
        for (int i = 1; i < 8; i++) begin
          pv[i] <= pv[i-1];
          px[i] <= px[i-1];
        end
      end
    end

    always_comb begin
      yv = pv[lat-1];
      for (int j = 0; j < K; j++) yb[j*16 +: 16] = ref_isqrt(px[lat-1][j*32 +: 32]);
    end

    always @(posedge clk) if (rv) cnt <= cnt + 1;

    assign arg_rdy[g] = rdy;
    assign res_vld[g] = rv;
    assign res[g]     = r;
    assign xv_all[g]  = MAXK'(xv);
    assign x_all[g]   = (MAXK*32)'(xb);
    assign pulses[g]  = cnt;
  end

  function automatic logic [MAXK-1:0] lane_mask(int c, int b);
    logic [MAXK-1:0] m = '0;
    for (int j = 0; j < cfg_k(c); j++) m[j] = (b * cfg_k(c) + j < cfg_n(c));
    return m;
  endfunction

  function automatic logic [MAXK*32-1:0] lane_data(int c, int b);
    logic [MAXK*32-1:0] d = '0;
    for (int j = 0; j < cfg_k(c); j++)
      if (b * cfg_k(c) + j < cfg_n(c)) d[j*32 +: 32] = a[b * cfg_k(c) + j];
    return d;
  endfunction

  function automatic logic [31:0] ref_sum(int c);
    logic [31:0] s = 0;
    for (int i = 0; i < cfg_n(c); i++) s += 32'(ref_isqrt(a[i]));
    return s;
  endfunction

  task automatic pack_args();
    for (int i = 0; i < MAXN; i++) arg_all[i*32 +: 32] = a[i];
  endtask

  task automatic scramble();
    for (int i = 0; i < MAXN; i++) arg_all[i*32 +: 32] = $urandom;
  endtask

  task automatic rand_args();
    logic [31:0] r;
    for (int i = 0; i < MAXN; i++) begin
      r = 32'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0: a[i] = $urandom;
        1: a[i] = 32'hFFFF_FFFF;
        2: a[i] = r * r;
        default: a[i] = r * r - 1;
      endcase
    end
  endtask

  // Called at a falling edge with every instance idle; returns at a falling edge.
  task automatic run_op(int c, string tag);
    int nb, due;
    logic [31:0] exp;
    bit seen;
    nb   = (cfg_n(c) + cfg_k(c) - 1) / cfg_k(c);
    due  = nb + lat;
    exp  = ref_sum(c);
    seen = 0;
    pack_args();
    arg_vld[c] = 1'b1;
    #1;
    check({tag, ".rdy0"}, arg_rdy[c], 1);
    check({tag, ".xv0"}, xv_all[c], lane_mask(c, 0));
    check({tag, ".x0"}, x_all[c], lane_data(c, 0));
    @(posedge clk);
    #1;
    arg_vld[c] = 1'b0;
    scramble();
    ops[c]++;
    #1;
    check({tag, ".rdy1"}, arg_rdy[c], 0);
    check({tag, ".xv1"}, xv_all[c], (nb > 1) ? lane_mask(c, 1) : '0);
    check({tag, ".x1"}, x_all[c], (nb > 1) ? lane_data(c, 1) : '0);
    for (int n = 1; n <= due + 2 && !seen; n++) begin
      @(negedge clk);
      if (res_vld[c]) begin
        seen = 1;
        check({tag, ".cycle"}, n, due);
        check({tag, ".res"}, res[c], exp);
        check({tag, ".rdy_at_res"}, arg_rdy[c], 1);
      end
    end
    if (!seen) check({tag, ".timeout"}, 0, 1);
    @(negedge clk);
    check({tag, ".single"}, res_vld[c], 0);
    check({tag, ".hold"}, res[c], exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp2;
    bit seen;
    rst_n   = 1'b0;
    arg_vld = '0;
    for (int c = 0; c < NCFG; c++) ops[c] = 0;
    scramble();
    arg_vld[0] = 1'b1;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("rst.rdy%0d", c), arg_rdy[c], 0);
      check($sformatf("rst.res_vld%0d", c), res_vld[c], 0);
      check($sformatf("rst.res%0d", c), res[c], 0);
      check($sformatf("rst.xv%0d", c), xv_all[c], 0);
      check($sformatf("rst.x%0d", c), x_all[c], 0);
    end
    arg_vld = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    a[0] = 1; a[1] = 4; a[2] = 9;
    run_op(0, "t1");
    check("t1.value", res[0], 6);

    a[0] = 16; a[1] = 25; a[2] = 36; a[3] = 49;
    run_op(1, "t2");
    check("t2.value", res[1], 22);

    a[0] = 100; a[1] = 0; a[2] = 32'hFFFF_FFFF;
    run_op(2, "t3");
    check("t3.value", res[2], 65545);

    // Back-to-back: arg_vld held high through the busy window.
    for (int i = 0; i < 3; i++) a[i] = 32'hFFFF_FFFF;
    pack_args();
    arg_vld[0] = 1'b1;
    #1;
    check("t4.rdy0", arg_rdy[0], 1);
    @(posedge clk);
    #1;
    ops[0]++;
    for (int i = 0; i < 3; i++) a[i] = 32'd15 + 32'(i);
    pack_args();
    exp2 = ref_sum(0);
    for (int n = 1; n <= 5; n++) begin
      #1;
      check("t4.rdy_busy", arg_rdy[0], 0);
      @(negedge clk);
      check("t4.no_res", res_vld[0], 0);
      @(posedge clk);
      #1;
    end
    check("t4.rdy6", arg_rdy[0], 1);
    @(negedge clk);
    check("t4.res_vld6", res_vld[0], 1);
    check("t4.res6", res[0], 196605);
    @(posedge clk);
    #1;
    arg_vld[0] = 1'b0;
    ops[0]++;
    scramble();
    seen = 0;
    for (int n = 7; n <= 16 && !seen; n++) begin
      @(negedge clk);
      if (res_vld[0]) begin
        seen = 1;
        check("t4.cycle2", n, 12);
        check("t4.res2", res[0], exp2);
      end
    end
    if (!seen) check("t4.timeout", 0, 1);
    @(negedge clk);

    // Asynchronous reset in the middle of ISSUE.
    rand_args();
    run_op(5, "t5pre");
    rand_args();
    pack_args();
    arg_vld[5] = 1'b1;
    @(posedge clk);
    #1;
    arg_vld[5] = 1'b0;
    #1;
    check("t5.xv_pre", xv_all[5], lane_mask(5, 1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.xv_rst", xv_all[5], 0);
    check("t5.x_rst", x_all[5], 0);
    check("t5.rdy_rst", arg_rdy[5], 0);
    check("t5.res_rst", res[5], 0);
    check("t5.res0_rst", res[0], 0);
    check("t5.res_vld_rst", res_vld[5], 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check("t5.no_res", res_vld[5], 0);
    end
    a[0] = 1; a[1] = 1; a[2] = 1;
    run_op(0, "t5");
    check("t5.value", res[0], 3);

    for (int l = 1; l <= 8; l++) begin
      lat = l;
      repeat (10) @(negedge clk);
      for (int c = 0; c < NCFG; c++) begin
        for (int r = 0; r < 3; r++) begin
          rand_args();
          run_op(c, $sformatf("sweep.L%0d.c%0d", l, c));
        end
      end
    end

    repeat (2) @(negedge clk);
    for (int c = 0; c < NCFG; c++) check($sformatf("pulses%0d", c), pulses[c], ops[c]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
